// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: shifts an n-bit LSB-first frame in after a
// start pulse and presents completed words through a valid/ready holding register.
module sipo_deser #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         serial_in,
    input  logic         clr_ovf,
    input  logic         out_ready,
    output logic [n-1:0] parallel_out,
    output logic         out_valid,
    output logic         busy,
    output logic         overflow
);

    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic {IDLE, RECV} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [n-1:0]    sr_q, sr_d;
    logic [n-1:0]    pout_q, pout_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;
    logic [n-1:0]    word;
    logic            done;

    assign word = {serial_in, sr_q[n-1:1]};

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        pout_d  = pout_q;
        valid_d = valid_q;
        ovf_d   = ovf_q & ~clr_ovf;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                if (start) begin
                    cnt_d = '0;
                end else begin
                    sr_d  = word;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && out_ready) valid_d = 1'b0;

        // A completed word either lands in the holding register or is dropped; set beats clear.
        if (done) begin
            if (!valid_q || out_ready) begin
                pout_d  = word;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign parallel_out = pout_q;
    assign out_valid    = valid_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q == RECV);

endmodule
